// File: rtl/ptp_event_capture.sv
// rtl/ptp_event_capture.sv - timestamps async event edges against PTP time into a FIFO
// Define PTP_EVENT_CAPTURE_COMP_EN to subtract COMP_NS (one extra pipeline cycle).
module ptp_event_capture #(
  parameter int          FIFO_DEPTH  = 8,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_SEL    = 0,
  parameter logic [29:0] COMP_NS     = 30'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] input_ts_96,
  input  logic        input_ts_step,
  input  logic        enable,
  input  logic        event_in,
  output logic [95:0] output_ts,
  output logic        output_ts_step,
  output logic        output_ts_valid,
  input  logic        output_ts_ready,
  input  logic        status_clear,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_last;
  logic                   rise;
  logic                   fall;
  logic                   edge_hit;
  logic                   capture;
  logic [95:0]            raw_entry;
  logic                   unused_ts_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~hist_q;
  assign fall      = ~sync_last & hist_q;
  assign edge_hit  = (EDGE_SEL == 0) ? rise : (EDGE_SEL == 1) ? fall : (rise | fall);
  assign capture   = edge_hit & enable;
  assign level     = sync_last;

  // Bits [47:46] of the PTP word are padding and always stored as zero.
  assign raw_entry      = {input_ts_96[95:48], 2'b00, input_ts_96[45:0]};
  assign unused_ts_bits = ^input_ts_96[47:46];

  logic        wr_req;
  logic [95:0] wr_data;

`ifdef PTP_EVENT_CAPTURE_COMP_EN
  logic        stage_valid;
  logic [47:0] stage_sec;
  logic [45:0] stage_nsf;
  logic [46:0] diff;
  logic        borrow;
  logic [29:0] ns_adj;
  logic [47:0] sec_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_sec   <= '0;
      stage_nsf   <= '0;
    end else begin
      stage_valid <= capture;
      if (capture) begin
        stage_sec <= raw_entry[95:48];
        stage_nsf <= raw_entry[45:0];
      end
    end
  end

  // {ns,fns} minus {COMP_NS,0}; a borrow rolls the stamp back into the previous second.
  assign diff    = {1'b0, stage_nsf} - {1'b0, COMP_NS, 16'd0};
  assign borrow  = diff[46];
  assign ns_adj  = borrow ? (diff[45:16] + 30'd1_000_000_000) : diff[45:16];
  assign sec_adj = borrow ? (stage_sec - 48'd1) : stage_sec;
  assign wr_req  = stage_valid;
  assign wr_data = {sec_adj, 2'b00, ns_adj, diff[15:0]};
`else
  localparam logic [29:0] unused_comp_ns = COMP_NS;
  assign wr_req  = capture;
  assign wr_data = raw_entry;
`endif

  logic [96:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        rd_en;
  logic        wr_en;
  logic        drop;
  logic        step_q;
  logic [96:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = ~empty & output_ts_ready;
  assign wr_en = wr_req & (~full | rd_en);
  assign drop  = wr_req & ~wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {step_q, wr_data};
  end

  // A step in the same cycle as a write belongs to the next entry, so set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                step_q <= 1'b0;
    else if (input_ts_step) step_q <= 1'b1;
    else if (wr_en)         step_q <= 1'b0;
  end

  assign head            = mem[rd_ptr[AW-1:0]];
  assign output_ts_valid = ~empty;
  assign output_ts       = empty ? 96'd0 : head[95:0];
  assign output_ts_step  = ~empty & head[96];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (status_clear) begin
      overflow   <= drop;
      drop_count <= {15'd0, drop};
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ptp_event_capture.sv
// tb/tb_ptp_event_capture.sv - self-checking bench for ptp_event_capture
module tb_ptp_event_capture;

  localparam int          D   = 8;
  localparam int          S   = 2;
  localparam int          ES  = 0;
  localparam logic [29:0] CNS = 30'd16;
`ifdef PTP_EVENT_CAPTURE_COMP_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic        clk, rst;
  logic [95:0] input_ts_96;
  logic        input_ts_step, enable, event_in, output_ts_ready, status_clear;
  logic [95:0] output_ts;
  logic        output_ts_step, output_ts_valid, overflow, level;
  logic [15:0] drop_count;

  ptp_event_capture #(.FIFO_DEPTH(D), .SYNC_STAGES(S), .EDGE_SEL(ES), .COMP_NS(CNS)) dut (
    .clk(clk), .rst(rst), .input_ts_96(input_ts_96), .input_ts_step(input_ts_step),
    .enable(enable), .event_in(event_in), .output_ts(output_ts),
    .output_ts_step(output_ts_step), .output_ts_valid(output_ts_valid),
    .output_ts_ready(output_ts_ready), .status_clear(status_clear),
    .overflow(overflow), .drop_count(drop_count), .level(level));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic use_fixed = 1'b1;
  logic chk_en = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: an edge seen on the pin at posedge k is written at posedge k+S(+LAT).
  typedef struct {logic [95:0] ts; logic step;} ent_t;
  ent_t        q[$];
  logic        h[0:4];
  logic        mstep;
  logic        mov;
  logic [15:0] mdrop;
  logic        pend_v;
  logic [95:0] pend_ts;

`ifdef PTP_EVENT_CAPTURE_COMP_EN
  function automatic logic [95:0] comp(input logic [95:0] t);
    longint f;
    logic [47:0] sec;
    logic [63:0] fu;
    f   = longint'(t[45:16]) * 65536 + longint'(t[15:0]) - longint'(CNS) * 65536;
    sec = t[95:48];
    if (f < 0) begin
      f   = f + 64'sd1000000000 * 65536;
      sec = sec - 48'd1;
    end
    fu = 64'(f);
    return {sec, 2'b00, fu[45:16], fu[15:0]};
  endfunction
`endif

  always @(posedge clk) begin
    logic        cur, prev, det, rd, wreq, wr_ok, dropped;
    logic [95:0] wts, raw;
    if (rst) begin
      q.delete();
      for (int i = 0; i < 5; i++) h[i] = 1'b0;
      mstep = 0; mov = 0; mdrop = 0; pend_v = 0; pend_ts = '0;
    end else begin
      cur  = h[S-1];
      prev = h[S];
      case (ES)
        0:       det = cur && !prev;
        1:       det = !cur && prev;
        default: det = cur != prev;
      endcase
      det = det && enable;
      raw = {input_ts_96[95:48], 2'b00, input_ts_96[45:0]};
`ifdef PTP_EVENT_CAPTURE_COMP_EN
      wreq    = pend_v;
      wts     = comp(pend_ts);
      pend_v  = det;
      pend_ts = raw;
`else
      wreq = det;
      wts  = raw;
`endif
      rd      = (q.size() != 0) && output_ts_ready;
      wr_ok   = wreq && ((q.size() < D) || rd);
      dropped = wreq && !wr_ok;
      if (rd) void'(q.pop_front());
      if (wr_ok) q.push_back('{ts: wts, step: mstep});
      if (input_ts_step) mstep = 1;
      else if (wr_ok)    mstep = 0;
      if (status_clear) begin
        mov   = dropped;
        mdrop = dropped ? 16'd1 : 16'd0;
      end else if (dropped) begin
        mov = 1;
        if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
      for (int i = 4; i > 0; i--) h[i] = h[i-1];
      h[0] = event_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("valid", {95'd0, output_ts_valid}, {95'd0, q.size() != 0});
      chk("ts", output_ts, (q.size() != 0) ? q[0].ts : 96'd0);
      chk("step", {95'd0, output_ts_step}, {95'd0, (q.size() != 0) && q[0].step});
      chk("overflow", {95'd0, overflow}, {95'd0, mov});
      chk("drop_count", {80'd0, drop_count}, {80'd0, mdrop});
      chk("level", {95'd0, level}, {95'd0, h[S-1]});
    end
  end

  always @(posedge clk) begin
    #2;
    cyc++;
    if (!use_fixed) input_ts_96 = {48'(cyc + 1000), 2'b11, 30'(cyc * 7 + 3), 16'(cyc * 13)};
  end

  task automatic step_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic edge_pulse();
    event_in = 1'b1;
    step_cyc(3);
    event_in = 1'b0;
    step_cyc(3);
  endtask

  task automatic drain(output int n, output logic [7:0] st);
    n  = 0;
    st = '0;
    output_ts_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!output_ts_valid) break;
      if (n < 8) st[n] = output_ts_step;
      n++;
      step_cyc(1);
    end
    output_ts_ready = 1'b0;
    chk("drain_bound", {95'd0, output_ts_valid}, 96'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, lat;
    logic [7:0] st;
    rst = 1'b1; input_ts_step = 0; enable = 1; event_in = 0;
    output_ts_ready = 0; status_clear = 0;
`ifdef PTP_EVENT_CAPTURE_COMP_EN
    input_ts_96 = {48'd7, 2'b00, 30'd10, 16'h8000};
`else
    input_ts_96 = {48'd5, 2'b00, 30'd100, 16'd0};
`endif
    step_cyc(3);
    chk("rst_valid", {95'd0, output_ts_valid}, 96'd0);
    chk("rst_ts", output_ts, 96'd0);
    chk("rst_drop", {80'd0, drop_count}, 96'd0);
    chk("rst_overflow", {95'd0, overflow}, 96'd0);
    chk("rst_level", {95'd0, level}, 96'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    step_cyc(2);

    // First edge with a fixed timestamp: latency and value
    event_in = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step_cyc(1);
      lat++;
      if (output_ts_valid) break;
    end
    chk("latency", 96'(lat), 96'(S + 1 + LAT));
`ifdef PTP_EVENT_CAPTURE_COMP_EN
    chk("ts_comp", output_ts, {48'd6, 2'b00, 30'd999_999_994, 16'h8000});
`else
    chk("ts_raw", output_ts, {48'd5, 2'b00, 30'd100, 16'd0});
`endif
    drain(n, st);
    chk("first_count", 96'(n), 96'd1);
    event_in = 1'b0;
    step_cyc(6);
    chk("fall_no_entry", {95'd0, output_ts_valid}, 96'd0);
    use_fixed = 1'b0;

    // Overflow: 10 edges into an 8-deep FIFO with no reader
    repeat (10) edge_pulse();
    step_cyc(4);
    chk("ovf_flag", {95'd0, overflow}, 96'd1);
    chk("ovf_drops", {80'd0, drop_count}, 96'd2);
    status_clear = 1'b1;
    step_cyc(1);
    status_clear = 1'b0;
    chk("clr_flag", {95'd0, overflow}, 96'd0);
    chk("clr_drops", {80'd0, drop_count}, 96'd0);
    drain(n, st);
    chk("ovf_count", 96'(n), 96'd8);

    // Full FIFO with a read on the same edge as a write
    repeat (8) edge_pulse();
    event_in = 1'b1;
    step_cyc(S + LAT);
    output_ts_ready = 1'b1;
    step_cyc(1);
    output_ts_ready = 1'b0;
    event_in = 1'b0;
    step_cyc(4);
    chk("fullrd_drops", {80'd0, drop_count}, 96'd0);
    drain(n, st);
    chk("fullrd_count", 96'(n), 96'd8);

    // Step between captures 1 and 2
    edge_pulse();
    input_ts_step = 1'b1;
    step_cyc(1);
    input_ts_step = 1'b0;
    step_cyc(2);
    edge_pulse();
    edge_pulse();
    drain(n, st);
    chk("step_count", 96'(n), 96'd3);
    chk("step_flags", {93'd0, st[2:0]}, 96'b010);

    // Enable low: edge is discarded
    enable = 1'b0;
    edge_pulse();
    step_cyc(3);
    chk("enable_low", {95'd0, output_ts_valid}, 96'd0);
    enable = 1'b1;

    // Asynchronous reset with entries queued
    repeat (3) edge_pulse();
    step_cyc(3);
    chk("pre_rst_valid", {95'd0, output_ts_valid}, 96'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {95'd0, output_ts_valid}, 96'd0);
    step_cyc(2);
    rst = 1'b0;
    step_cyc(2);
    edge_pulse();
    step_cyc(3);
    drain(n, st);
    chk("post_rst_count", 96'(n), 96'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
